// File: rtl/axi_read_xbar.sv
// Read-path crossbar: three AXI masters to six slaves plus an internal DECERR slave.
// One read burst is in flight bridge-wide; masters are served round-robin.
module axi_read_xbar #(
   parameter int ID_BITS    = 4,
   parameter int ADDR_BITS  = 32,
   parameter int DATA_BITS  = 32,
   parameter int LEN_BITS   = 4,
   localparam int IDS_BITS  = ID_BITS + 4,
   localparam int AR_W      = IDS_BITS + ADDR_BITS + LEN_BITS + 3 + 2,
   localparam int MAR_W     = AR_W - 4,
   localparam int R_W       = IDS_BITS + DATA_BITS + 2 + 1,
   localparam int MR_W      = ID_BITS + DATA_BITS + 3
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic [3*MAR_W-1:0]   m_ar,
   input  logic [2:0]           m_arvalid,
   output logic [2:0]           m_arready,
   output logic [MR_W-1:0]      m_r,
   output logic [2:0]           m_rvalid,
   input  logic [2:0]           m_rready,
   output logic [AR_W-1:0]      s_ar,
   output logic [5:0]           s_arvalid,
   input  logic [5:0]           s_arready,
   input  logic [6*R_W-1:0]     s_r,
   input  logic [5:0]           s_rvalid,
   output logic [5:0]           s_rready
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

   localparam logic [2:0] SEL_DFLT = 3'd6;

   state_e               state_q, state_d;
   logic [1:0]           g_q, g_d;
   logic [1:0]           ptr_q, ptr_d;
   logic [2:0]           sel_q, sel_d;
   logic [LEN_BITS-1:0]  cnt_q, cnt_d;
   logic [ID_BITS-1:0]   rid_q, rid_d;

   logic [MAR_W-1:0]     m_ar_arr [3];
   logic [R_W-1:0]       s_r_arr [6];
   logic [MAR_W-1:0]     gm_ar_s;
   logic [R_W-1:0]       sel_r_s;
   logic [1:0]           grant_s;
   logic [2:0]           idx_s;
   logic                 found_s;
   logic [2:0]           dec_sel_s;
   logic                 is_dflt_s;
   logic                 sel_arready_s;
   logic                 sel_rvalid_s;
   logic                 ar_hs_s;
   logic                 r_hs_s;
   logic                 rlast_s;
   logic [IDS_BITS-ID_BITS-1:0] unused_rid_hi_s;

   function automatic logic [2:0] addr_decode(input logic [ADDR_BITS-1:0] a);
      logic [2:0] s;
      if (a <= ADDR_BITS'(32'h0000_1FFF)) begin
         s = 3'd0;
      end else if (a >= ADDR_BITS'(32'h0001_0000) && a <= ADDR_BITS'(32'h0001_FFFF)) begin
         s = 3'd1;
      end else if (a >= ADDR_BITS'(32'h0002_0000) && a <= ADDR_BITS'(32'h0002_FFFF)) begin
         s = 3'd2;
      end else if (a >= ADDR_BITS'(32'h1002_0000) && a <= ADDR_BITS'(32'h1002_0400)) begin
         s = 3'd3;
      end else if (a >= ADDR_BITS'(32'h1001_0000) && a <= ADDR_BITS'(32'h1001_03FF)) begin
         s = 3'd4;
      end else if (a >= ADDR_BITS'(32'h2000_0000) && a <= ADDR_BITS'(32'h201F_FFFF)) begin
         s = 3'd5;
      end else begin
         s = SEL_DFLT;
      end
      return s;
   endfunction

   // Slice the flat master/slave buses into per-port arrays.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         m_ar_arr[i] = m_ar[i*MAR_W +: MAR_W];
      end
      for (int j = 0; j < 6; j++) begin
         s_r_arr[j] = s_r[j*R_W +: R_W];
      end
   end

   // Round-robin pick: first requester at or after the pointer, then decode its address.
   always_comb begin
      grant_s = ptr_q;
      found_s = 1'b0;
      idx_s   = 3'd0;
      for (int k = 0; k < 3; k++) begin
         idx_s = {1'b0, ptr_q} + 3'(k);
         if (idx_s >= 3'd3) begin
            idx_s = idx_s - 3'd3;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && m_arvalid[idx_s[1:0]]) begin
            grant_s = idx_s[1:0];
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      dec_sel_s = addr_decode(m_ar_arr[grant_s][MAR_W-ID_BITS-1 -: ADDR_BITS]);
   end

   // Routing only ever uses the latched grant and slave select.
   always_comb begin
      is_dflt_s     = (sel_q == SEL_DFLT);
      gm_ar_s       = m_ar_arr[g_q];
      sel_arready_s = 1'b0;
      sel_rvalid_s  = 1'b0;
      sel_r_s       = '0;
      if (!is_dflt_s) begin
         sel_arready_s = s_arready[sel_q];
         sel_rvalid_s  = s_rvalid[sel_q];
         sel_r_s       = s_r_arr[sel_q];
      end else begin
         sel_r_s       = '0;
      end
      unused_rid_hi_s = sel_r_s[R_W-1 -: IDS_BITS-ID_BITS];
      ar_hs_s = (state_q == ADDR) && (is_dflt_s || sel_arready_s);
      rlast_s = is_dflt_s ? (cnt_q == '0) : sel_r_s[0];
      r_hs_s  = (state_q == DATA) && (is_dflt_s || sel_rvalid_s) && m_rready[g_q];
   end

   // Next-state logic for the burst FSM, arbitration pointer and DECERR beat counter.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      rid_d   = rid_q;
      case (state_q)
         IDLE: begin
            if (|m_arvalid) begin
               g_d     = grant_s;
               sel_d   = dec_sel_s;
               state_d = ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         ADDR: begin
            if (ar_hs_s) begin
               state_d = DATA;
               cnt_d   = gm_ar_s[5 +: LEN_BITS];
               rid_d   = gm_ar_s[MAR_W-1 -: ID_BITS];
            end else begin
               state_d = ADDR;
            end
         end
         DATA: begin
            if (r_hs_s && rlast_s) begin
               state_d = IDLE;
               ptr_d   = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;
            end else if (r_hs_s && is_dflt_s) begin
               cnt_d   = cnt_q - LEN_BITS'(1);
            end else begin
               state_d = DATA;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; a reset mid-burst abandons the burst.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         g_q     <= 2'd0;
         ptr_q   <= 2'd0;
         sel_q   <= 3'd0;
         cnt_q   <= '0;
         rid_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         rid_q   <= rid_d;
      end
   end

   // Port muxing: everything not belonging to the current grant/select is held at zero.
   always_comb begin
      m_arready = 3'b000;
      m_rvalid  = 3'b000;
      m_r       = '0;
      s_ar      = '0;
      s_arvalid = 6'b000000;
      s_rready  = 6'b000000;
      case (state_q)
         ADDR: begin
            s_ar = {4'(g_q), gm_ar_s};
            if (is_dflt_s) begin
               m_arready[g_q] = 1'b1;
            end else begin
               s_arvalid[sel_q] = 1'b1;
               m_arready[g_q]   = sel_arready_s;
            end
         end
         DATA: begin
            if (is_dflt_s) begin
               m_rvalid[g_q] = 1'b1;
               m_r           = {rid_q, DATA_BITS'(0), 2'b11, rlast_s};
            end else begin
               m_rvalid[g_q]   = sel_rvalid_s;
               s_rready[sel_q] = m_rready[g_q];
               m_r             = {sel_r_s[R_W-IDS_BITS+ID_BITS-1 -: ID_BITS], sel_r_s[DATA_BITS+2:0]};
            end
         end
         default: begin
            m_r = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_read_xbar.sv
// Scoreboard bench for axi_read_xbar: master request queues, a single behavioural
// slave responder, and per-master expected/observed R-beat queues.
module tb_axi_read_xbar;

   localparam int MAR_W = 45;
   localparam int AR_W  = 49;
   localparam int R_W   = 43;
   localparam int MR_W  = 39;

   logic                ACLK = 1'b0;
   logic                ARESET;
   logic [3*MAR_W-1:0]  m_ar;
   logic [2:0]          m_arvalid;
   logic [2:0]          m_arready;
   logic [MR_W-1:0]     m_r;
   logic [2:0]          m_rvalid;
   logic [2:0]          m_rready;
   logic [AR_W-1:0]     s_ar;
   logic [5:0]          s_arvalid;
   logic [5:0]          s_arready;
   logic [6*R_W-1:0]    s_r;
   logic [5:0]          s_rvalid;
   logic [5:0]          s_rready;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
   } req_t;

   req_t             req_q [3][$];
   logic [MR_W-1:0]  exp_q [3][$];
   logic [MR_W-1:0]  obs_q [3][$];
   logic [1:0]       grant_q [$];
   int               checks = 0;
   int               errors = 0;
   logic             toggle = 1'b0;

   logic             sl_act;
   logic [2:0]       sl_idx;
   logic [7:0]       sl_id;
   logic [31:0]      sl_addr;
   logic [3:0]       sl_len;
   logic [3:0]       sl_beat;

   axi_read_xbar dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .m_ar      (m_ar),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_r       (m_r),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .s_ar      (s_ar),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_r       (s_r),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready)
   );

   always #5 ACLK = ~ACLK;

   // Behavioural slave: accepts one AR, then streams len+1 beats honouring RREADY.
   always @(posedge ACLK) begin
      if (ARESET) begin
         sl_act <= 1'b0;
      end else if (!sl_act) begin
         for (int j = 0; j < 6; j++) begin
            if (s_arvalid[j] && s_arready[j]) begin
               sl_act  <= 1'b1;
               sl_idx  <= 3'(j);
               sl_id   <= s_ar[48:41];
               sl_addr <= s_ar[40:9];
               sl_len  <= s_ar[8:5];
               sl_beat <= 4'd0;
            end
         end
      end else if (s_rready[sl_idx]) begin
         if (sl_beat == sl_len) sl_act <= 1'b0;
         else sl_beat <= sl_beat + 4'd1;
      end
   end

   // Every slave slice carries a distinct data pattern so misrouting shows up.
   always_comb begin
      s_rvalid = sl_act ? (6'b000001 << sl_idx) : 6'b000000;
      for (int j = 0; j < 6; j++) begin
         s_r[j*R_W +: R_W] = {sl_id, sl_addr + 32'(sl_beat) + (32'(j) << 24), 2'b00, (sl_beat == sl_len)};
      end
   end

   function automatic logic [2:0] tb_decode(input logic [31:0] a);
      if (a <= 32'h0000_1FFF) return 3'd0;
      if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 3'd1;
      if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 3'd2;
      if (a >= 32'h1002_0000 && a <= 32'h1002_0400) return 3'd3;
      if (a >= 32'h1001_0000 && a <= 32'h1001_03FF) return 3'd4;
      if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 3'd5;
      return 3'd6;
   endfunction

   function automatic logic all_done();
      logic d;
      d = (m_arvalid == 3'b000);
      for (int i = 0; i < 3; i++) begin
         if (req_q[i].size() != 0 || obs_q[i].size() < exp_q[i].size()) d = 1'b0;
      end
      return d;
   endfunction

   task automatic issue(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
      req_t r;
      logic [2:0] sel;
      logic [31:0] d;
      r.id = id;
      r.addr = addr;
      r.len = len;
      req_q[m].push_back(r);
      sel = tb_decode(addr);
      for (int b = 0; b <= int'(len); b++) begin
         if (sel == 3'd6) begin
            exp_q[m].push_back({id, 32'h0000_0000, 2'b11, (b == int'(len))});
         end else begin
            d = addr + 32'(b) + (32'(sel) << 24);
            exp_q[m].push_back({id, d, 2'b00, (b == int'(len))});
         end
      end
   endtask

   // One clock: present queued requests, sample handshakes mid-cycle, retire accepted ARs.
   task automatic step();
      logic [2:0] hs;
      req_t r;
      for (int i = 0; i < 3; i++) begin
         if (!m_arvalid[i] && req_q[i].size() > 0) begin
            r = req_q[i].pop_front();
            m_ar[i*MAR_W +: MAR_W] = {r.id, r.addr, r.len, 3'b010, 2'b01};
            m_arvalid[i] = 1'b1;
         end
      end
      @(negedge ACLK);
      hs = m_arvalid & m_arready;
      for (int i = 0; i < 3; i++) begin
         if (hs[i]) grant_q.push_back(2'(i));
         if (m_rvalid[i] && m_rready[i]) obs_q[i].push_back(m_r);
      end
      @(posedge ACLK);
      #1;
      m_arvalid = m_arvalid & ~hs;
      if (toggle) m_rready[0] = ~m_rready[0];
   endtask

   task automatic run(input int budget, output logic to);
      int n;
      n = 0;
      to = 1'b0;
      while (!all_done()) begin
         if (n >= budget) begin
            to = 1'b1;
            break;
         end
         step();
         n++;
      end
      if (!to) repeat (3) step();
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      m_ar = {3{45'h1_2345_6789_AB}};
      m_arvalid = 3'b111;
      repeat (2) @(posedge ACLK);
      #1;
      checks++; if (m_arready !== 3'b000) begin errors++; $display("FAIL rst_arready: got %b want 000", m_arready); end
      checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL rst_rvalid: got %b want 000", m_rvalid); end
      checks++; if (s_arvalid !== 6'b000000) begin errors++; $display("FAIL rst_s_arvalid: got %b want 0", s_arvalid); end
      checks++; if (s_rready !== 6'b000000) begin errors++; $display("FAIL rst_s_rready: got %b want 0", s_rready); end
      checks++; if (m_r !== '0) begin errors++; $display("FAIL rst_m_r: got %h want 0", m_r); end
      checks++; if (s_ar !== '0) begin errors++; $display("FAIL rst_s_ar: got %h want 0", s_ar); end
      m_arvalid = 3'b000;
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_single_dm();
      logic to;
      logic [MR_W-1:0] e, o;
      grant_q.delete();
      issue(1, 4'd5, 32'h0002_0010, 4'd3);
      step();
      checks++; if (s_arvalid !== 6'b000100) begin errors++; $display("FAIL dm_s_arvalid: got %b want 000100", s_arvalid); end
      checks++; if (s_ar[48:41] !== 8'h15) begin errors++; $display("FAIL dm_arid_s: got %h want 15", s_ar[48:41]); end
      checks++; if (m_arready !== 3'b010) begin errors++; $display("FAIL dm_arready: got %b want 010", m_arready); end
      run(100, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL dm_timeout: got %b want 0", to); end
      for (int i = 0; i < 3; i++) begin
         while (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            checks++;
            if (obs_q[i].size() == 0) begin errors++; $display("FAIL dm_beat m%0d: got none want %h", i, e); end
            else begin
               o = obs_q[i].pop_front();
               if (o !== e) begin errors++; $display("FAIL dm_beat m%0d: got %h want %h", i, o, e); end
            end
         end
         checks++; if (obs_q[i].size() != 0) begin errors++; $display("FAIL dm_extra m%0d: got %0d want 0", i, obs_q[i].size()); obs_q[i].delete(); end
      end
   endtask

   task automatic test_round_robin();
      logic to;
      logic [MR_W-1:0] e, o;
      logic [1:0] exp_g [4];
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      grant_q.delete();
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
      issue(0, 4'd1, 32'h0001_0000, 4'd0);
      issue(1, 4'd2, 32'h0001_0004, 4'd0);
      issue(2, 4'd3, 32'h0001_0008, 4'd0);
      issue(0, 4'd4, 32'h0001_000C, 4'd0);
      run(200, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rr_timeout: got %b want 0", to); end
      checks++; if (grant_q.size() != 4) begin errors++; $display("FAIL rr_grant_count: got %0d want 4", grant_q.size()); end
      for (int k = 0; k < 4; k++) begin
         if (grant_q.size() > 0) begin
            o[1:0] = grant_q.pop_front();
            checks++;
            if (o[1:0] !== exp_g[k]) begin errors++; $display("FAIL rr_grant%0d: got M%0d want M%0d", k, o[1:0], exp_g[k]); end
         end
      end
      for (int i = 0; i < 3; i++) begin
         while (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            checks++;
            if (obs_q[i].size() == 0) begin errors++; $display("FAIL rr_beat m%0d: got none want %h", i, e); end
            else begin
               o = obs_q[i].pop_front();
               if (o !== e) begin errors++; $display("FAIL rr_beat m%0d: got %h want %h", i, o, e); end
            end
         end
         checks++; if (obs_q[i].size() != 0) begin errors++; $display("FAIL rr_extra m%0d: got %0d want 0", i, obs_q[i].size()); obs_q[i].delete(); end
      end
   endtask

   task automatic test_default_slave();
      logic to;
      logic [MR_W-1:0] e, o;
      issue(2, 4'd12, 32'h3000_0000, 4'd2);
      step();
      checks++; if (m_arready !== 3'b100) begin errors++; $display("FAIL dflt_arready: got %b want 100", m_arready); end
      checks++; if (s_arvalid !== 6'b000000) begin errors++; $display("FAIL dflt_s_arvalid: got %b want 0", s_arvalid); end
      run(100, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL dflt_timeout: got %b want 0", to); end
      for (int i = 0; i < 3; i++) begin
         while (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            checks++;
            if (obs_q[i].size() == 0) begin errors++; $display("FAIL dflt_beat m%0d: got none want %h", i, e); end
            else begin
               o = obs_q[i].pop_front();
               if (o !== e) begin errors++; $display("FAIL dflt_beat m%0d: got %h want %h", i, o, e); end
            end
         end
         checks++; if (obs_q[i].size() != 0) begin errors++; $display("FAIL dflt_extra m%0d: got %0d want 0", i, obs_q[i].size()); obs_q[i].delete(); end
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [MR_W-1:0] e, o;
      issue(0, 4'd9, 32'h2000_0100, 4'd7);
      toggle = 1'b1;
      n = 0;
      while (!all_done() && n < 200) begin
         step();
         #1;
         if (s_rvalid[5]) begin
            checks++;
            if (s_rready[5] !== m_rready[0]) begin errors++; $display("FAIL bp_mirror: got %b want %b", s_rready[5], m_rready[0]); end
         end
         n++;
      end
      toggle = 1'b0;
      m_rready = 3'b111;
      checks++; if (n >= 200) begin errors++; $display("FAIL bp_timeout: got %0d cycles want <200", n); end
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         while (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            checks++;
            if (obs_q[i].size() == 0) begin errors++; $display("FAIL bp_beat m%0d: got none want %h", i, e); end
            else begin
               o = obs_q[i].pop_front();
               if (o !== e) begin errors++; $display("FAIL bp_beat m%0d: got %h want %h", i, o, e); end
            end
         end
         checks++; if (obs_q[i].size() != 0) begin errors++; $display("FAIL bp_extra m%0d: got %0d want 0", i, obs_q[i].size()); obs_q[i].delete(); end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic to;
      int n;
      logic [MR_W-1:0] e, o;
      issue(1, 4'd3, 32'h0001_0040, 4'd0);
      run(100, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rmb_pre_timeout: got %b want 0", to); end
      checks++; if (obs_q[1].size() != 1) begin errors++; $display("FAIL rmb_pre_beats: got %0d want 1", obs_q[1].size()); end
      exp_q[1].delete();
      obs_q[1].delete();
      issue(1, 4'd7, 32'h0002_0040, 4'd3);
      n = 0;
      while (obs_q[1].size() < 2 && n < 100) begin
         step();
         n++;
      end
      checks++; if (n >= 100) begin errors++; $display("FAIL rmb_wait: got %0d beats want 2", obs_q[1].size()); end
      ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      checks++; if (m_arready !== 3'b000) begin errors++; $display("FAIL rmb_arready: got %b want 000", m_arready); end
      checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL rmb_rvalid: got %b want 000", m_rvalid); end
      checks++; if (s_arvalid !== 6'b000000) begin errors++; $display("FAIL rmb_s_arvalid: got %b want 0", s_arvalid); end
      checks++; if (s_rready !== 6'b000000) begin errors++; $display("FAIL rmb_s_rready: got %b want 0", s_rready); end
      checks++; if (m_r !== '0) begin errors++; $display("FAIL rmb_m_r: got %h want 0", m_r); end
      ARESET = 1'b0;
      exp_q[1].delete();
      obs_q[1].delete();
      grant_q.delete();
      issue(1, 4'd10, 32'h0001_0020, 4'd0);
      issue(2, 4'd11, 32'h0001_0030, 4'd0);
      run(100, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rmb_timeout: got %b want 0", to); end
      checks++;
      if (grant_q.size() != 2) begin errors++; $display("FAIL rmb_grants: got %0d grants want 2", grant_q.size()); end
      else begin
         o[1:0] = grant_q.pop_front();
         if (o[1:0] !== 2'd1) begin errors++; $display("FAIL rmb_first_grant: got M%0d want M1", o[1:0]); end
      end
      for (int i = 0; i < 3; i++) begin
         while (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            checks++;
            if (obs_q[i].size() == 0) begin errors++; $display("FAIL rmb_beat m%0d: got none want %h", i, e); end
            else begin
               o = obs_q[i].pop_front();
               if (o !== e) begin errors++; $display("FAIL rmb_beat m%0d: got %h want %h", i, o, e); end
            end
         end
         checks++; if (obs_q[i].size() != 0) begin errors++; $display("FAIL rmb_extra m%0d: got %0d want 0", i, obs_q[i].size()); obs_q[i].delete(); end
      end
   endtask

   initial begin
      ARESET    = 1'b1;
      m_ar      = '0;
      m_arvalid = 3'b000;
      m_rready  = 3'b111;
      s_arready = 6'b111111;
      test_reset();
      test_single_dm();
      test_round_robin();
      test_default_slave();
      test_backpressure();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
